// File: rtl/ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_ctrl
// Description : Valid/ready request front end for a 512x32 synchronous ram.
//               Converts byte addresses to word addresses, sequences the
//               ram's one-cycle registered read, and performs partial-word
//               writes as read-modify-write. One response per request, with
//               an error flag for misaligned addresses.
//               Optional macro RAM_CTRL_STATS_EN adds saturating 16-bit
//               read/write/error counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [3:0]        i_req_be,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic [ADDR_W-3:0] o_ram_addr,
  output logic              o_ram_wEn,
  output logic [DATA_W-1:0] o_ram_wDat,
  output logic              o_ram_rEn,
  input  logic [DATA_W-1:0] i_ram_rDat
`ifdef RAM_CTRL_STATS_EN
  ,
  output logic [15:0]       o_stat_rd,
  output logic [15:0]       o_stat_wr,
  output logic [15:0]       o_stat_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_CAP  = 3'd2,
    S_RMW_RD  = 3'd3,
    S_RMW_MRG = 3'd4,
    S_WR      = 3'd5,
    S_RESP    = 3'd6
  } state_t;

  localparam logic [3:0] C_BE_FULL = 4'hF;

  state_t              r_state;
  state_t              w_next;
  logic                r_write;
  logic [ADDR_W-3:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_be;
  logic [DATA_W-1:0]   r_merge;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                w_accept;
  logic                w_misaligned;
  logic                w_resp_hs;

  assign o_req_ready  = (r_state == S_IDLE) && !i_reset;
  assign w_accept     = i_req_valid && o_req_ready;
  assign w_misaligned = (i_req_addr[1:0] != 2'b00);
  assign w_resp_hs    = (r_state == S_RESP) && i_resp_ready;

  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

  // Ram strobes and address are decoded from state so reset kills them at once
  assign o_ram_addr = (r_state == S_IDLE) ? '0 : r_waddr;
  assign o_ram_rEn  = (r_state == S_RD) || (r_state == S_RMW_RD);
  assign o_ram_wEn  = (r_state == S_WR) && r_write;
  assign o_ram_wDat = (r_state != S_WR) ? '0 :
                      (r_be == C_BE_FULL) ? r_wdata : r_merge;

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misaligned)                 w_next = S_RESP;
          else if (!i_req_write)            w_next = S_RD;
          else if (i_req_be == 4'h0)        w_next = S_RESP;
          else if (i_req_be == C_BE_FULL)   w_next = S_WR;
          else                              w_next = S_RMW_RD;
        end
      end
      S_RD:      w_next = S_RD_CAP;
      S_RD_CAP:  w_next = S_RESP;
      S_RMW_RD:  w_next = S_RMW_MRG;
      S_RMW_MRG: w_next = S_WR;
      S_WR:      w_next = S_RESP;
      S_RESP:    if (i_resp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Request latch, read capture, byte merge and response registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_write <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_merge <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= i_req_write;
        r_waddr <= i_req_addr[ADDR_W-1:2];
        r_wdata <= i_req_wdata;
        r_be    <= i_req_be;
        r_rdata <= '0;
        r_err   <= w_misaligned;
      end
      if (r_state == S_RD_CAP) begin
        r_rdata <= i_ram_rDat;
      end
      if (r_state == S_RMW_MRG) begin
        for (int i = 0; i < 4; i++) begin
          r_merge[8*i +: 8] <= r_be[i] ? r_wdata[8*i +: 8] : i_ram_rDat[8*i +: 8];
        end
      end
      if (w_resp_hs) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

`ifdef RAM_CTRL_STATS_EN
  logic [15:0] r_stat_rd;
  logic [15:0] r_stat_wr;
  logic [15:0] r_stat_err;

  assign o_stat_rd  = r_stat_rd;
  assign o_stat_wr  = r_stat_wr;
  assign o_stat_err = r_stat_err;

  // Saturating completion counters, bumped on the response handshake
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_stat_rd  <= '0;
      r_stat_wr  <= '0;
      r_stat_err <= '0;
    end else if (w_resp_hs) begin
      if (r_err) begin
        if (r_stat_err != 16'hFFFF) r_stat_err <= r_stat_err + 16'd1;
      end else if (r_write) begin
        if (r_stat_wr != 16'hFFFF) r_stat_wr <= r_stat_wr + 16'd1;
      end else begin
        if (r_stat_rd != 16'hFFFF) r_stat_rd <= r_stat_rd + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_ctrl
// Description : Self-checking bench for ram_ctrl with a behavioural 512x32
//               ram and a scoreboard of expected responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, resp_ready;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [8:0]  ram_addr;
  logic        ram_wEn, ram_rEn;
  logic [31:0] ram_wDat;
  logic [31:0] ram_rDat;
`ifdef RAM_CTRL_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_err;
`endif

  ram_ctrl dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_be     (req_be),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_ram_addr   (ram_addr),
    .o_ram_wEn    (ram_wEn),
    .o_ram_wDat   (ram_wDat),
    .o_ram_rEn    (ram_rEn),
    .i_ram_rDat   (ram_rDat)
`ifdef RAM_CTRL_STATS_EN
    ,
    .o_stat_rd    (stat_rd),
    .o_stat_wr    (stat_wr),
    .o_stat_err   (stat_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural synchronous ram, write wins over read
  logic [31:0] mem [0:511];
  always @(posedge clk) begin
    if (ram_rEn) ram_rDat <= mem[ram_addr];
    if (ram_wEn) mem[ram_addr] <= ram_wDat;
  end

  // Strobe monitor, sampled mid-cycle
  int          rcnt = 0, wcnt = 0, both_cnt = 0;
  logic [8:0]  last_waddr = '0;
  logic [31:0] last_wdat = '0;
  always @(negedge clk) begin
    if (ram_rEn) rcnt++;
    if (ram_wEn) begin
      wcnt++;
      last_waddr = ram_addr;
      last_wdat  = ram_wDat;
    end
    if (ram_rEn && ram_wEn) both_cnt++;
  end

  int n_checks = 0, n_fail = 0;
  logic [31:0] ref_mem [0:511];
  logic [32:0] sb_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) until the controller is ready, then drive for one edge
  task automatic wait_ready(output bit ok);
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    ok = req_ready;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic w, input logic [10:0] a, input logic [31:0] d,
                      input logic [3:0] be, input int hold);
    logic [8:0]  idx;
    logic [31:0] exp_rd, exp_wdat, old;
    logic        exp_err;
    logic [32:0] item;
    int          exp_lat, er, ew, lat, r0, w0;
    bit          ok;
    idx = a[10:2];
    exp_rd = '0; exp_err = 1'b0; exp_wdat = '0;
    if (a[1:0] != 2'b00) begin
      exp_err = 1'b1; exp_lat = 0; er = 0; ew = 0;
    end else if (w) begin
      if (be == 4'h0)      begin exp_lat = 0; er = 0; ew = 0; end
      else if (be == 4'hF) begin exp_lat = 1; er = 0; ew = 1; end
      else                 begin exp_lat = 3; er = 1; ew = 1; end
      old = ref_mem[idx];
      for (int i = 0; i < 4; i++)
        if (be[i]) old[8*i +: 8] = d[8*i +: 8];
      ref_mem[idx] = old;
      exp_wdat = old;
    end else begin
      exp_lat = 2; er = 1; ew = 0; exp_rd = ref_mem[idx];
    end
    sb_q.push_back({exp_err, exp_rd});

    wait_ready(ok);
    if (!ok) begin
      void'(sb_q.pop_front());
      return;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    r0 = rcnt; w0 = wcnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    item = sb_q.pop_front();
    if (!resp_valid) return;
    check("rdata", 64'(resp_rdata), 64'(item[31:0]));
    check("err", 64'(resp_err), 64'(item[32]));
    check("rEn_cycles", 64'(rcnt - r0), 64'(er));
    check("wEn_cycles", 64'(wcnt - w0), 64'(ew));
    if (ew != 0) begin
      check("wr_addr", 64'(last_waddr), 64'(idx));
      check("wr_data", 64'(last_wdat), 64'(exp_wdat));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_rdata", 64'(resp_rdata), 64'(item[31:0]));
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("post_hs_valid", 64'(resp_valid), 64'd0);
    check("post_hs_rdata", 64'(resp_rdata), 64'd0);
    check("post_hs_err", 64'(resp_err), 64'd0);
    check("post_hs_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    bit ok;
    int w0;
    for (int i = 0; i < 512; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", 64'(resp_rdata), 64'd0);
    check("rst_strobes", 64'({ram_rEn, ram_wEn}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_ready", 64'(req_ready), 64'd1);

    send(1'b0, 11'h000, 32'h0, 4'h0, 0);
    send(1'b1, 11'h010, 32'hDEADBEEF, 4'hF, 0);
    send(1'b0, 11'h010, 32'h0, 4'h0, 0);
    send(1'b1, 11'h010, 32'h11223344, 4'b0101, 0);
    send(1'b0, 11'h010, 32'h0, 4'h0, 5);
    send(1'b0, 11'h013, 32'h0, 4'h0, 0);
    send(1'b1, 11'h020, 32'hCAFEF00D, 4'h0, 0);
    send(1'b0, 11'h020, 32'h0, 4'h0, 0);
    send(1'b1, 11'h7FE, 32'h12345678, 4'hF, 0);

    for (int n = 0; n < 12; n++) begin
      logic [10:0] a;
      a = {6'd0, 3'($urandom_range(0, 7)), 2'b00};
      send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 0);
    end

    // Partial write to the top word, reset lands while in RMW_MRG
    wait_ready(ok);
    if (ok) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h7FC;
      req_wdata = 32'hA5A5A5A5; req_be = 4'b0011;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      w0 = wcnt;
      rst = 1'b1;
      #1;
      check("midrst_valid", 64'(resp_valid), 64'd0);
      check("midrst_wEn", 64'(ram_wEn), 64'd0);
      check("midrst_ready", 64'(req_ready), 64'd0);
`ifdef RAM_CTRL_STATS_EN
      check("stat_rd_rst", 64'(stat_rd), 64'd0);
      check("stat_wr_rst", 64'(stat_wr), 64'd0);
      check("stat_err_rst", 64'(stat_err), 64'd0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_idle", 64'(req_ready), 64'd1);
      check("midrst_no_resp", 64'(resp_valid), 64'd0);
      check("midrst_no_write", 64'(wcnt - w0), 64'd0);
    end
    send(1'b0, 11'h7FC, 32'h0, 4'h0, 0);
    send(1'b1, 11'h7FC, 32'h0BADF00D, 4'b1100, 0);
    send(1'b0, 11'h7FC, 32'h0, 4'h0, 0);

    check("strobe_exclusive", 64'(both_cnt), 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
